// File: rtl/data_memory_responder.sv
// Data-memory responder: valid/ready load/store requests served from a byte-lane RAM
// after a fixed number of wait states, with a registered response channel.
module data_memory_responder #(
    parameter int unsigned MEM_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDRESS = 32'h80000000,
    parameter int unsigned WAIT_STATES  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_address,
    input  logic [31:0] req_write_data,
    input  logic [3:0]  req_byte_enable,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_read_data,
    output logic        resp_error
);

    localparam int          AW           = $clog2(MEM_WORDS);
    localparam logic [32:0] WINDOW_BYTES = 33'(4 * MEM_WORDS);
    localparam logic [3:0]  WAIT_INIT    = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;

    logic        write_p0;
    logic [29:0] address_p0;
    logic [31:0] wdata_p0;
    logic [3:0]  be_p0;

    logic        acc_write;
    logic [29:0] acc_address;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic        acc_in_range;
    logic [AW-1:0] acc_index;
    logic        commit;

    logic [31:0] mem [MEM_WORDS];

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^req_address[1:0];

    // Offset is taken modulo 2^32, so a wrapped address fails the lower-bound test instead of aliasing.
    function automatic logic in_window(input logic [31:0] addr);
        logic [31:0] offset;
        offset = addr - BASE_ADDRESS;
        return (addr >= BASE_ADDRESS) && ({1'b0, offset} < WINDOW_BYTES);
    endfunction

    assign req_ready = (state == IDLE) && reset;

    // With zero wait states the access happens at the acceptance edge, before the latch is loaded.
    assign acc_write    = (state == IDLE) ? req_write            : write_p0;
    assign acc_address  = (state == IDLE) ? req_address[31:2]    : address_p0;
    assign acc_wdata    = (state == IDLE) ? req_write_data       : wdata_p0;
    assign acc_be       = (state == IDLE) ? req_byte_enable      : be_p0;
    assign acc_in_range = in_window({acc_address, 2'b00});
    assign acc_index    = acc_address[AW-1:0];
    assign commit       = reset && (state != RESPOND) && (state_next == RESPOND);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (!reset) begin
            state_next = IDLE;
            cnt_next   = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state_next = (WAIT_STATES == 0) ? RESPOND : WAIT;
                        cnt_next   = WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state_next = RESPOND;
                    end else begin
                        cnt_next = cnt - 4'd1;
                    end
                end
                RESPOND: begin
                    if (resp_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Request capture stage
    always_ff @(posedge clock) begin
        if (req_valid && req_ready) begin
            write_p0   <= req_write;
            address_p0 <= req_address[31:2];
            wdata_p0   <= req_write_data;
            be_p0      <= req_byte_enable;
        end
    end

    always_ff @(posedge clock) begin
        if (commit && acc_write && acc_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem[acc_index][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response stage
    always_ff @(posedge clock) begin
        if (!reset) begin
            resp_valid     <= 1'b0;
            resp_read_data <= 32'd0;
            resp_error     <= 1'b0;
        end else if (commit) begin
            resp_valid     <= 1'b1;
            resp_error     <= !acc_in_range;
            resp_read_data <= (acc_in_range && !acc_write) ? mem[acc_index] : 32'd0;
        end else if ((state == RESPOND) && resp_ready) begin
            resp_valid     <= 1'b0;
            resp_read_data <= 32'd0;
            resp_error     <= 1'b0;
        end
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the data-memory interface driven by the single-cycle datapath and its bus wrapper.
- Accepts load/store requests through a valid/ready handshake and serves them from an internal word-addressed RAM with byte lanes.
- Inserts a programmable number of wait states and returns data or an error through a registered valid/ready response channel.
- Sits between the core's data-memory port and the testbench/SoC memory map.

Parameters:
- MEM_WORDS, 1024, depth of the internal RAM in 32-bit words; must be a power of two.
- BASE_ADDRESS, 32'h80000000, byte address of word 0; must be aligned to 4*MEM_WORDS.
- WAIT_STATES, 1, cycles spent in WAIT between acceptance and response; range 0..15.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1=store, 0=load.
- req_address  in  32  byte address; bits [1:0] ignored.
- req_write_data  in  32  store data, lane-aligned.
- req_byte_enable  in  4  store lane mask; bit i selects bits [8i+7:8i].
- resp_valid  out  1  response present.
- resp_ready  in  1  requester consumes the response.
- resp_read_data  out  32  load data; 0 for stores and for errors.
- resp_error  out  1  address outside the RAM window.

Behaviour:
- Reset: state=IDLE, resp_valid=0, resp_read_data=0, resp_error=0, wait counter=0. RAM contents are not cleared.
- req_ready is combinational: 1 only when state==IDLE and reset==1.
- While reset==0, req_valid is ignored.
- FSM states: IDLE, WAIT, RESPOND.
- IDLE:
  - On req_valid&&req_ready, latch write, address, data and byte_enable.
  - Go to WAIT with counter=WAIT_STATES-1, or go directly to RESPOND if WAIT_STATES==0.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter==0, go to RESPOND at the next edge.
- Access: performed at the edge that enters RESPOND.
  - In range means BASE_ADDRESS <= addr < BASE_ADDRESS+4*MEM_WORDS.
  - Index = (addr-BASE_ADDRESS)[log2(MEM_WORDS)+1:2].
  - Store: only enabled lanes are written. byte_enable==0 is a legal no-op that still returns a normal response.
  - Load: returns the full 32-bit word regardless of byte_enable.
  - Out of range: nothing is written, resp_read_data=0, resp_error=1.
- Latency: resp_valid first rises WAIT_STATES+1 cycles after the acceptance edge.
- RESPOND:
  - resp_valid=1. resp_read_data and resp_error are held stable until the handshake.
  - On resp_ready, return to IDLE at that edge and clear resp_valid, resp_read_data and resp_error to 0.
  - Backpressure may last indefinitely.
- Throughput: at most one transaction per WAIT_STATES+2 cycles. No overlap; req_ready=0 in WAIT and RESPOND.
- Ordering: a load accepted after a store's response completes observes that store.
- Reset mid-operation: return to IDLE and drop the pending response.
  - A store not yet in RESPOND is not performed.
  - A store already committed remains in RAM.
- An address wrap (BASE_ADDRESS+offset overflowing 32 bits) is out of range, never aliased.

Test Plan (WAIT_STATES=1 unless noted):
1. Reset for 2 cycles, then release -> req_ready=1, resp_valid=0, resp_read_data=0, resp_error=0 in the first cycle after release.
2. Store 0xDEADBEEF to 0x80000010 with be=4'hF, then load 0x80000010 -> load response 0xDEADBEEF with resp_error=0; resp_valid rises 2 cycles after each acceptance.
3. Prior word 0xDEADBEEF, store 0x00AA5500 to 0x80000010 with be=4'b0110, then load -> 0xDEAA55EF.
4. Load 0x80001000 (one past the end for 1024 words) and store to 0x00000000 -> resp_error=1, resp_read_data=0; a reload of 0x80000000 is unchanged.
5. Hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid and data stable and req_ready=0 throughout; on resp_ready=1, return to IDLE with req_ready=1 on the next cycle.
6. WAIT_STATES=0: accept a store 0x12345678 to 0x80000004, then assert reset during RESPOND before the handshake -> resp_valid=0 after reset; a later load returns 0x12345678. A second store reset during WAIT (WAIT_STATES=3) leaves the old word.
